// File: rtl/riscv_trace_pkg.sv
// Shared types for the retire-trace unit: FSM states, instruction classes,
// the trace entry layout and the opcode classifier.
package riscv_trace_pkg;

  localparam int TRACE_DW    = 32;
  localparam int NUM_CLASSES = 6;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {CAPTURE, HALTED, DRAIN, DONE} trace_state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_UNKNOWN
  } inst_class_e;

  typedef struct packed {
    logic [TRACE_DW-1:0] pc;
    logic [TRACE_DW-1:0] inst;
    logic [TRACE_DW-1:0] data;
  } trace_entry_t;

  function automatic inst_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_RTYPE:  return CLS_RTYPE;
      OPC_IALU:   return CLS_IALU;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      default:    return CLS_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/riscv_trace_if.sv
// Retire input and drain output bundle of the trace unit.
interface riscv_trace_if #(
  parameter int DATAWIDTH = 32
);
  logic                 retire_valid;
  logic [DATAWIDTH-1:0] retire_pc;
  logic [DATAWIDTH-1:0] retire_inst;
  logic [DATAWIDTH-1:0] retire_data;

  logic                 read_valid;
  logic                 read_ready;
  logic                 read_last;
  logic [DATAWIDTH-1:0] read_pc;
  logic [DATAWIDTH-1:0] read_inst;
  logic [DATAWIDTH-1:0] read_data;

  modport slave (
    input  retire_valid, retire_pc, retire_inst, retire_data, read_ready,
    output read_valid, read_last, read_pc, read_inst, read_data
  );

  modport master (
    output retire_valid, retire_pc, retire_inst, retire_data, read_ready,
    input  read_valid, read_last, read_pc, read_inst, read_data
  );
endinterface

// File: rtl/trace_ring.sv
// DEPTH-entry ring of trace entries; a write into a full ring drops the
// oldest entry and reports it on overwrite.
module trace_ring
  import riscv_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  entry_t        wr_entry,
  input  logic          rd_en,
  output entry_t        rd_entry,
  output logic [CW-1:0] count,
  output logic          overwrite
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overwrite = 1'b0;
    if (wr_en) begin
      wptr_d = wptr_q + PW'(1);
      // Full: advance the read side too so count stays saturated at DEPTH.
      if (count_q == CW'(DEPTH)) begin
        rptr_d    = rptr_q + PW'(1);
        overwrite = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (rd_en && count_q != '0) begin
      rptr_d  = rptr_q + PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= wr_entry;
  end

  assign rd_entry = mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/riscv_trace_unit.sv
// Retire-trace capture: records retired instructions, halts on end PC or
// self-loop, then drains. Optional per-class counters: TRACE_CLASS_COUNT_EN.
module riscv_trace_unit
  import riscv_trace_pkg::*;
#(
  parameter int  DATAWIDTH  = 32,
  parameter int  DEPTH      = 16,
  parameter int  ENDPC      = 0,
  parameter int  STALLLIMIT = 8,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  riscv_trace_if.slave                   tr,
  output logic                           halt,
  output logic                           overflow,
  output logic [CW-1:0]                  entry_count,
  output logic [NUM_CLASSES-1:0][15:0]   class_count
);

  localparam int SW = $clog2(STALLLIMIT + 1);

  typedef struct packed {
    logic [DATAWIDTH-1:0] pc;
    logic [DATAWIDTH-1:0] inst;
    logic [DATAWIDTH-1:0] data;
  } entry_t;

  trace_state_e         state_q, state_d;
  logic                 halt_q, halt_d;
  logic                 overflow_q, overflow_d;
  logic [DATAWIDTH-1:0] prev_pc_q, prev_pc_d;
  logic [SW-1:0]        stall_q, stall_d;

  logic          capture_wr, end_hit, stall_hit, overwrite, drain_pop;
  logic [SW-1:0] stall_next;
  logic [CW-1:0] count;
  entry_t        wr_entry, rd_entry;

  assign capture_wr = (state_q == CAPTURE) && tr.retire_valid;
  // stall_q==0 means no previous retire, so the first pc starts a fresh run.
  assign stall_next = (stall_q != '0 && tr.retire_pc == prev_pc_q) ?
                      stall_q + SW'(1) : SW'(1);
  assign stall_hit  = (stall_next == SW'(STALLLIMIT));
  assign end_hit    = (ENDPC != 0) && ((tr.retire_pc >> 2) >= DATAWIDTH'(ENDPC));
  assign wr_entry   = '{pc: tr.retire_pc, inst: tr.retire_inst, data: tr.retire_data};

  trace_ring #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (capture_wr),
    .wr_entry  (wr_entry),
    .rd_en     (drain_pop),
    .rd_entry  (rd_entry),
    .count     (count),
    .overwrite (overwrite)
  );

  always_comb begin
    state_d    = state_q;
    halt_d     = halt_q;
    overflow_d = overflow_q | overwrite;
    prev_pc_d  = prev_pc_q;
    stall_d    = stall_q;
    case (state_q)
      CAPTURE: begin
        if (capture_wr) begin
          prev_pc_d = tr.retire_pc;
          stall_d   = stall_next;
          if (end_hit || stall_hit) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end
        end
      end
      HALTED:  state_d = DRAIN;
      DRAIN:   if (count == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= CAPTURE;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
      prev_pc_q  <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
      prev_pc_q  <= prev_pc_d;
      stall_q    <= stall_d;
    end
  end

  // Fields are gated by read_valid so nothing stale shows outside DRAIN.
  assign tr.read_valid = (state_q == DRAIN) && (count != '0);
  assign drain_pop     = tr.read_valid && tr.read_ready;
  assign tr.read_last  = tr.read_valid && (count == CW'(1));
  assign tr.read_pc    = tr.read_valid ? rd_entry.pc   : '0;
  assign tr.read_inst  = tr.read_valid ? rd_entry.inst : '0;
  assign tr.read_data  = tr.read_valid ? rd_entry.data : '0;

  assign halt        = halt_q;
  assign overflow    = overflow_q;
  assign entry_count = count;

`ifdef TRACE_CLASS_COUNT_EN
  logic [NUM_CLASSES-1:0][15:0] cls_cnt_q, cls_cnt_d;
  inst_class_e                  cls;

  assign cls = classify(tr.retire_inst[6:0]);

  // Only CAPTURE retires count, so counters freeze once halted.
  always_comb begin
    cls_cnt_d = cls_cnt_q;
    if (capture_wr) cls_cnt_d[cls] = cls_cnt_q[cls] + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cls_cnt_q <= '0;
    else       cls_cnt_q <= cls_cnt_d;
  end

  assign class_count = cls_cnt_q;
`else
  assign class_count = '0;
`endif

endmodule
